move_queue: RTL and testbench

Input front-end for the 2048 game core. It debounces a parametrised bank of raw push-buttons and optionally decodes UART keystrokes. Each accepted press becomes a direction command that is buffered in a FIFO. Commands are presented to the game controller over a valid/ready handshake, so no move is lost while the controller or the board printer is busy.

---
 rtl/move_queue.sv | 247 ++++++++++++++++++++++++
 tb/tb_move_queue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_queue.sv
// ----------------------------------------------------------------------------
// move_queue
// Input front-end for the 2048 game core. Raw push-buttons are synchronised
// and debounced; each debounced press (and, optionally, each decoded UART
// keystroke) becomes a direction command buffered in a register FIFO and
// offered to the game controller over a valid/ready handshake.
//
// Optional feature macro: MOVE_QUEUE_UART_EN
//   defined     : rx_data/rx_valid are decoded ('w','d','s','a', any case)
//                 into commands 0..3 and compete with buttons for the push.
//   not defined : rx_data/rx_valid are ignored, no decode logic is built.
//
// Ports:
//   clk        sole clock
//   rst        asynchronous active-low reset
//   btn        raw asynchronous button levels, active-high (button i -> code i)
//   rx_data    UART received byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   flush      synchronous FIFO clear (new game); drop_cnt is kept
//   cmd        head command, IDLE_CODE when empty (registered)
//   cmd_valid  FIFO non-empty (registered)
//   cmd_ready  consumer accepts head when cmd_valid && cmd_ready
//   level      current FIFO occupancy
//   drop_cnt   saturating count of lost commands
// ----------------------------------------------------------------------------
module move_queue #(
  parameter int NUM_BTNS        = 4,
  parameter int CMD_W           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEPTH           = 8,
  parameter int IDLE_CODE       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BTNS-1:0]    btn,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   flush,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int CAND_W = $clog2(NUM_BTNS + 2);

  // The counter toggles the state on the edge that would take it to
  // DEBOUNCE_CYCLES, so it only ever needs to hold DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CMD_W-1:0] IDLE_CMD = CMD_W'(IDLE_CODE);

  // Number of set bits in a press vector.
  function automatic logic [CAND_W-1:0] count_ones(input logic [NUM_BTNS-1:0] v);
    logic [CAND_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      n = n + CAND_W'(v[i]);
    end
    return n;
  endfunction

  // Debounce pipeline state
  logic [NUM_BTNS-1:0] sync1_r;
  logic [NUM_BTNS-1:0] sync2_r;
  logic [NUM_BTNS-1:0] db_r;
  logic [NUM_BTNS-1:0] db_prev_r;
  logic [NUM_BTNS-1:0] press_r;
  logic [CNT_W-1:0]    cnt_r [NUM_BTNS];

  // FIFO state
  logic [CMD_W-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [LVL_W-1:0]    level_r;
  logic [7:0]          drop_r;
  logic [CMD_W-1:0]    cmd_r;
  logic                cmd_valid_r;

  // Arbitration / next-state signals
  logic [CMD_W-1:0]    btn_code_s;
  logic                uart_hit_s;
  logic [CMD_W-1:0]    uart_code_s;
  logic [CAND_W-1:0]   cand_cnt_s;
  logic [CAND_W-1:0]   lose_cnt_s;
  logic                push_req_s;
  logic [CMD_W-1:0]    push_code_s;
  logic                pop_s;
  logic                full_s;
  logic                push_ok_s;
  logic                ovf_s;
  logic [8:0]          drop_sum_s;
  logic                wr_en_s;
  logic [PTR_W-1:0]    rd_ptr_n_s;
  logic [PTR_W-1:0]    wr_ptr_n_s;
  logic [LVL_W-1:0]    level_n_s;
  logic [7:0]          drop_n_s;
  logic [CMD_W-1:0]    cmd_n_s;

`ifdef MOVE_QUEUE_UART_EN
  // Map a keystroke to a direction; 3'd4 means "not a move key".
  // OR-ing 0x20 folds upper case onto lower case, and only the two case
  // variants of each letter land on the matched values.
  function automatic logic [2:0] decode_key(input logic [7:0] b);
    logic [7:0] lc;
    logic [2:0] k;
    lc = b | 8'h20;
    case (lc)
      8'h77:   k = 3'd0;  // w
      8'h64:   k = 3'd1;  // d
      8'h73:   k = 3'd2;  // s
      8'h61:   k = 3'd3;  // a
      default: k = 3'd4;
    endcase
    return k;
  endfunction

  logic [2:0] key_s;

  // UART candidate: a mapped key whose code has a matching button slot.
  always_comb begin
    key_s       = decode_key(rx_data);
    uart_hit_s  = rx_valid && (key_s != 3'd4) && (int'(key_s) < NUM_BTNS);
    uart_code_s = CMD_W'(key_s);
  end
`else
  logic unused_uart_s;
  assign unused_uart_s = ^{rx_data, rx_valid};

  // No UART source in this build.
  always_comb begin
    uart_hit_s  = 1'b0;
    uart_code_s = '0;
  end
`endif

  // Synchronise, debounce and edge-detect every button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      db_r      <= '0;
      db_prev_r <= '0;
      press_r   <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r   <= btn;
      sync2_r   <= sync1_r;
      db_prev_r <= db_r;
      press_r   <= db_r & ~db_prev_r;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= ~db_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lowest-index press wins (scan from the top so low indices overwrite).
  always_comb begin
    btn_code_s = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      btn_code_s = press_r[i] ? CMD_W'(i) : btn_code_s;
    end
  end

  // Arbitration, drop accounting and FIFO next state, including the head
  // value the output register will hold after this edge.
  always_comb begin
    cand_cnt_s  = count_ones(press_r) + CAND_W'(uart_hit_s);
    push_req_s  = (|press_r) | uart_hit_s;
    push_code_s = (|press_r) ? btn_code_s : uart_code_s;
    lose_cnt_s  = push_req_s ? (cand_cnt_s - CAND_W'(1)) : '0;
    pop_s       = (level_r != '0) & cmd_ready;
    full_s      = (level_r == LVL_FULL);
    push_ok_s   = push_req_s & (~full_s | pop_s);
    ovf_s       = push_req_s & full_s & ~pop_s;
    drop_sum_s  = {1'b0, drop_r} + 9'(lose_cnt_s) + 9'(ovf_s);

    if (flush) begin
      wr_en_s    = 1'b0;
      rd_ptr_n_s = '0;
      wr_ptr_n_s = '0;
      level_n_s  = '0;
      drop_n_s   = drop_r;
    end else begin
      wr_en_s    = push_ok_s;
      rd_ptr_n_s = rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_n_s = wr_ptr_r + PTR_W'(push_ok_s);
      level_n_s  = level_r + LVL_W'(push_ok_s) - LVL_W'(pop_s);
      drop_n_s   = (drop_sum_s > 9'd255) ? 8'd255 : drop_sum_s[7:0];
    end

    // The entry being written this edge becomes the head when it lands on
    // the next read slot (empty FIFO, or popping the last entry).
    if (level_n_s == '0) begin
      cmd_n_s = IDLE_CMD;
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_n_s)) begin
      cmd_n_s = push_code_s;
    end else begin
      cmd_n_s = mem_r[rd_ptr_n_s];
    end
  end

  // FIFO pointers, occupancy, drop counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      level_r     <= '0;
      drop_r      <= 8'd0;
      cmd_r       <= IDLE_CMD;
      cmd_valid_r <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_ptr_n_s;
      wr_ptr_r    <= wr_ptr_n_s;
      level_r     <= level_n_s;
      drop_r      <= drop_n_s;
      cmd_r       <= cmd_n_s;
      cmd_valid_r <= (level_n_s != '0);
    end
  end

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_code_s;
    end
  end

  assign cmd       = cmd_r;
  assign cmd_valid = cmd_valid_r;
  assign level     = level_r;
  assign drop_cnt  = drop_r;

endmodule

// File: tb/tb_move_queue.sv
// ----------------------------------------------------------------------------
// tb_move_queue
// Self-checking bench for move_queue (DEBOUNCE_CYCLES=4, DEPTH=4, NUM_BTNS=4).
// A reference model tracks raw button samples, decides debounce toggles from
// the last DEBOUNCE_CYCLES synchronised samples, and keeps the FIFO as a
// queue; DUT outputs are compared to it after every clock edge.
// ----------------------------------------------------------------------------
module tb_move_queue;

  localparam int NB   = 4;
  localparam int CW   = 3;
  localparam int DB   = 4;
  localparam int DP   = 4;
  localparam int IDLE = 4;
  localparam int RING = 16;

`ifdef MOVE_QUEUE_UART_EN
  localparam bit UART_EN = 1'b1;
`else
  localparam bit UART_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn = '0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          flush = 1'b0;
  logic          cmd_ready = 1'b0;
  logic [CW-1:0] cmd;
  logic          cmd_valid;
  logic [2:0]    level;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  move_queue #(
    .NUM_BTNS(NB), .CMD_W(CW), .DEBOUNCE_CYCLES(DB), .DEPTH(DP), .IDLE_CODE(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .rx_data(rx_data), .rx_valid(rx_valid),
    .flush(flush), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NB-1:0] samp_m [RING];   // raw btn sampled at edge k (ring)
  logic [NB-1:0] cand_m [RING];   // press candidates due at edge k (ring)
  logic [NB-1:0] db_m;
  int            q_m[$];
  int            drop_m;
  int            e_m;

  int            hold_r [NB];
  logic [7:0]    keys [12] = '{"w", "W", "a", "A", "s", "S", "d", "D", "x", "q", "1", 8'h00};
  int            exp_seq [4] = '{1, 2, 3, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int key_code(input logic [7:0] b);
    case (b)
      "w", "W": return 0;
      "d", "D": return 1;
      "s", "S": return 2;
      "a", "A": return 3;
      default:  return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < RING; k++) begin
      samp_m[k] = '0;
      cand_m[k] = '0;
    end
    db_m   = '0;
    q_m.delete();
    drop_m = 0;
    e_m    = 0;
  endtask

  // Advance the model over one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [NB-1:0] c;
    int  uc, n, win, k;
    bit  flip, s, pop;
    samp_m[e_m % RING] = btn;
    // The debounced state flips when the last DB synchronised samples (raw
    // samples two edges older) all differ from it; the command is pushed two
    // edges later (press register, then FIFO write).
    for (int i = 0; i < NB; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++) begin
        k = e_m - 2 - j;
        s = (k >= 0) ? samp_m[k % RING][i] : 1'b0;
        if (s == db_m[i]) flip = 1'b0;
      end
      if (flip) begin
        db_m[i] = ~db_m[i];
        if (db_m[i]) cand_m[(e_m + 2) % RING][i] = 1'b1;
      end
    end
    c = cand_m[e_m % RING];
    cand_m[e_m % RING] = '0;
    uc = -1;
    if (UART_EN && rx_valid) begin
      uc = key_code(rx_data);
      if (uc >= NB) uc = -1;
    end
    n   = $countones(c) + ((uc >= 0) ? 1 : 0);
    win = uc;
    for (int i = NB - 1; i >= 0; i--) begin
      if (c[i]) win = i;
    end
    if (flush) begin
      q_m.delete();
    end else begin
      if (n > 1) drop_m += n - 1;
      pop = (q_m.size() > 0) && cmd_ready;
      if (pop) void'(q_m.pop_front());
      if (n > 0) begin
        if (q_m.size() < DP) q_m.push_back(win);
        else drop_m++;
      end
      if (drop_m > 255) drop_m = 255;
    end
    e_m++;
  endtask

  task automatic compare_all();
    check("cmd", cmd, (q_m.size() > 0) ? q_m[0] : IDLE);
    check("cmd_valid", cmd_valid, q_m.size() > 0);
    check("level", level, q_m.size());
    check("drop_cnt", drop_cnt, drop_m);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic press(input int code);
    btn = '0;
    btn[code] = 1'b1;
    repeat (8) step();
    btn = '0;
    repeat (8) step();
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    repeat (DP + 1) step();
    cmd_ready = 1'b0;
  endtask

  initial begin
    int lat, drop_before;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_cmd", cmd, IDLE);
    rst = 1'b1;

    // Single press on button 1
    btn = 4'b0010;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (cmd_valid && lat < 0) lat = n;
    end
    check("press_latency", lat, DB + 3);
    check("press_cmd", cmd, 1);
    check("press_level", level, 1);
    btn = '0;
    repeat (12) step();
    check("release_level", level, 1);
    drain();

    // Bounce rejection on button 0
    for (int n = 0; n < 40; n++) begin
      btn[0] = ((n / 2) % 2) == 0;
      step();
      check("bounce_level", level, 0);
      check("bounce_drop", drop_cnt, 0);
    end
    btn = '0;
    repeat (8) step();

    // Simultaneous press of buttons 0 and 3
    btn = 4'b1001;
    repeat (12) step();
    btn = '0;
    repeat (8) step();
    check("simul_level", level, 1);
    check("simul_cmd", cmd, 0);
    check("simul_drop", drop_cnt, 1);
    drain();

    // Overflow: five presses into a depth-4 FIFO
    drop_before = drop_m;
    press(1); press(2); press(3); press(0); press(1);
    check("ovf_level", level, DP);
    check("ovf_drop", drop_cnt, drop_before + 1);
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_order", cmd, exp_seq[k]);
      step();
    end
    cmd_ready = 1'b0;
    check("ovf_idle", cmd, IDLE);

    // Full FIFO: push coinciding with pop
    press(3); press(2); press(1); press(0);
    drop_before = drop_m;
    btn = 4'b1000;
    for (int n = 0; n < 10; n++) begin
      cmd_ready = (cand_m[e_m % RING] != '0);
      step();
    end
    cmd_ready = 1'b0;
    btn = '0;
    repeat (8) step();
    check("fullpp_level", level, DP);
    check("fullpp_drop", drop_cnt, drop_before);
    cmd_ready = 1'b1;
    repeat (3) step();
    cmd_ready = 1'b0;
    check("fullpp_tail", cmd, 3);
    drain();

    // UART keystrokes and flush
    rx_data = "A"; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("uart_A_cmd", cmd, UART_EN ? 3 : IDLE);
    check("uart_A_level", level, UART_EN ? 1 : 0);
    rx_data = "x"; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("uart_x_level", level, UART_EN ? 1 : 0);
    drop_before = drop_m;
    rx_data = "w"; rx_valid = 1'b1; flush = 1'b1;
    step();
    rx_valid = 1'b0; flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_drop", drop_cnt, drop_before);

    // Drop counter saturation: all buttons at once into a full FIFO
    for (int n = 0; n < 70; n++) begin
      btn = 4'hF;
      rx_data = "a"; rx_valid = $urandom_range(0, 1) == 1;
      step();
      rx_valid = 1'b0;
      repeat (5) step();
      btn = '0;
      repeat (6) step();
    end
    check("drop_saturated", drop_cnt, 255);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Randomised traffic
    for (int i = 0; i < NB; i++) hold_r[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_r[i] == 0) begin
          btn[i]    = $urandom_range(0, 1) == 1;
          hold_r[i] = $urandom_range(1, 10);
        end else begin
          hold_r[i]--;
        end
      end
      rx_valid  = $urandom_range(0, 3) == 0;
      rx_data   = keys[$urandom_range(0, 11)];
      cmd_ready = $urandom_range(0, 2) == 0;
      flush     = $urandom_range(0, 60) == 0;
      step();
    end

    // Asynchronous reset mid-stream
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_cmd", cmd, IDLE);
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_drop", drop_cnt, 0);
    btn = '0; rx_valid = 1'b0; flush = 1'b0; cmd_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_r[i] == 0) begin
          btn[i]    = $urandom_range(0, 1) == 1;
          hold_r[i] = $urandom_range(1, 10);
        end else begin
          hold_r[i]--;
        end
      end
      rx_valid  = $urandom_range(0, 3) == 0;
      rx_data   = keys[$urandom_range(0, 11)];
      cmd_ready = $urandom_range(0, 3) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
